cam_capture: RTL and testbench
==============================

CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter H_PIX, default 320, SHALL set the pixels per stored line.
REQ-002 Parameter V_PIX, default 240, SHALL set the stored lines per frame.
REQ-003 Parameter AW, default 17, SHALL set the write address width; H_PIX*V_PIX SHALL be at most 2^AW.
REQ-004 CLK100MHZ  in  1  SHALL be the single system clock; every register SHALL be clocked on its rising edge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 pclk_cam  in  1  SHALL be the camera pixel clock, treated as data and never used as a clock.
REQ-007 vsync_cam  in  1  SHALL be the camera frame sync, active-high, asynchronous to CLK100MHZ.
REQ-008 href_cam  in  1  SHALL be the camera line-valid, active-high, asynchronous to CLK100MHZ.
REQ-009 wdata_cam  in  8  SHALL be the camera byte bus, valid at each pclk_cam rising edge.
REQ-010 cap_en  in  1  SHALL enable capture, sampled only at frame start.
REQ-011 waddr  out  AW  SHALL be the frame-buffer write address, row*H_PIX+col.
REQ-012 wdata  out  12  SHALL be the RGB444 pixel {R,G,B}.
REQ-013 wen  out  1  SHALL be a one-cycle write strobe qualifying waddr/wdata.
REQ-014 frame_done  out  1  SHALL pulse for one cycle when a captured frame ends.
REQ-015 ovf  out  1  SHALL be a sticky flag for bytes or lines dropped due to bounds.

Function
REQ-016 pclk_cam, vsync_cam, href_cam and wdata_cam SHALL each pass through a 2-flop synchronizer; data SHALL be taken from the stage aligned with the pclk_cam rising-edge detection (sync2 high, sync3 low).
REQ-017 The FSM SHALL have the states IDLE, WAIT_VS and ACTIVE.
REQ-018 IDLE -> WAIT_VS SHALL occur on a synchronized vsync rising edge.
REQ-019 WAIT_VS -> ACTIVE SHALL occur on a vsync falling edge when cap_en=1; if cap_en=0, the FSM SHALL return to IDLE.
REQ-020 ACTIVE -> WAIT_VS SHALL occur on a vsync rising edge, pulsing frame_done in the same cycle.
REQ-021 In ACTIVE, each pclk rise with href=1 SHALL capture a byte: even byte index R=byte[3:0]; odd byte index G=byte[7:4], B=byte[3:0].
REQ-022 wen SHALL assert exactly 2 CLK100MHZ cycles after the odd-byte pclk rise is detected, with waddr=row*H_PIX+col, and col SHALL then increment.
REQ-023 The href falling edge SHALL reset col and the byte phase to 0 and increment row; a dangling even byte SHALL be discarded without setting ovf.
REQ-024 Pixels with col>=H_PIX or row>=V_PIX SHALL NOT be written; each such pixel SHALL set ovf; waddr SHALL never exceed H_PIX*V_PIX-1 and SHALL never wrap.
REQ-025 A vsync rising edge mid-line SHALL abort the line, pulse frame_done, and reset row and col to 0 on the next frame start.
REQ-026 A pclk rise and an href fall in the same cycle SHALL process the byte first, then the line end.
REQ-027 Outside ACTIVE, wen SHALL remain 0.

Reset
REQ-028 While rst_n=0: the FSM SHALL be IDLE; waddr=0, wdata=0, wen=0, frame_done=0 and ovf=0; all synchronizers, counters and the byte phase SHALL be cleared.
REQ-029 Reset asserted mid-frame SHALL drop the partial frame; after release, capture SHALL resume only after a full vsync high-then-low sequence.
REQ-030 ovf SHALL clear only on reset.

Configuration
REQ-031 With CAM_DECIMATE_EN defined, only even input pixels of even input lines SHALL be written, mapping a 640x480 sensor onto H_PIX x V_PIX; odd pixels and lines SHALL neither advance col/row nor set ovf.
REQ-032 Without CAM_DECIMATE_EN, every input pixel and line SHALL be written per REQ-021 to REQ-024.

Verification
REQ-033 Reset, then vsync pulse, 1 line of 4 bytes 0x0A,0x5C,0x03,0xF1 -> wen twice: addr 0 data 0xA5C, addr 1 data 0x3F1.
REQ-034 Full 320x240 frame of incrementing pixels -> 76800 writes, last waddr=76799, one frame_done pulse, ovf=0.
REQ-035 Line of 642 bytes (321 pixels) -> 320 writes, ovf=1; next line starts at waddr=320.
REQ-036 cap_en=0 at the vsync fall -> zero wen for the whole frame; the next frame with cap_en=1 captures normally.
REQ-037 vsync rise at row 10 col 50 -> frame_done pulse; the next frame's first write is at waddr=0.
REQ-038 With CAM_DECIMATE_EN, a 640x480 frame -> 76800 writes, and input pixel (2,2) is written to waddr=321.

Source files
------------

// File: rtl/cam_capture_if.sv
// Camera capture bus: camera-side inputs plus the frame-buffer write port.
// The slave modport is the capture core; the master modport drives the camera
// pins and observes the write port.
interface cam_capture_if #(
  parameter int AW = 17
);
  logic          pclk_cam;
  logic          vsync_cam;
  logic          href_cam;
  logic [7:0]    wdata_cam;
  logic          cap_en;
  logic [AW-1:0] waddr;
  logic [11:0]   wdata;
  logic          wen;
  logic          frame_done;
  logic          ovf;

  modport master (
    output pclk_cam, vsync_cam, href_cam, wdata_cam, cap_en,
    input  waddr, wdata, wen, frame_done, ovf
  );

  modport slave (
    input  pclk_cam, vsync_cam, href_cam, wdata_cam, cap_en,
    output waddr, wdata, wen, frame_done, ovf
  );
endinterface

// File: rtl/cam_capture.sv
// Camera capture core: oversamples an 8-bit DVP camera bus on the system
// clock, packs byte pairs into RGB444 pixels and writes them row-major into a
// H_PIX x V_PIX frame buffer. Out-of-range pixels are dropped and flagged in
// the sticky ovf output.
// Optional build macro CAM_DECIMATE_EN: keep only even pixels of even lines
// (e.g. 640x480 sensor onto a 320x240 buffer).
module cam_capture #(
  parameter int H_PIX = 320,
  parameter int V_PIX = 240,
  parameter int AW    = 17
) (
  input logic          CLK100MHZ,
  input logic          rst_n,
  cam_capture_if.slave cam
);

  localparam int CW = $clog2(H_PIX + 1);
  localparam int RW = $clog2(V_PIX + 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_t;

  // bit 0 = sync1, bit 1 = sync2, bit 2 = sync3 (edge-detect history)
  logic [2:0]    pclk_s_q, vs_s_q, href_s_q;
  logic [7:0]    dat_s1_q, dat_s2_q;

  state_t        state_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          phase_q;
  logic [3:0]    r_q;
  logic          ovf_q;
  logic          frame_done_q;
`ifdef CAM_DECIMATE_EN
  logic          pix_odd_q;
  logic          line_odd_q;
`endif

  logic          vld_p0;
  logic [AW-1:0] addr_p0;
  logic [11:0]   pix_p0;

  logic          wen_q;
  logic [AW-1:0] waddr_q;
  logic [11:0]   wdata_q;

  logic          pclk_rise, vs_rise, vs_fall, href_fall, href_lvl;
  logic [7:0]    byte_s;
  logic          keep_d, keep_line_d, in_bounds_d;
  logic [AW-1:0] addr_d;

  assign pclk_rise = pclk_s_q[1] & ~pclk_s_q[2];
  assign vs_rise   = vs_s_q[1] & ~vs_s_q[2];
  assign vs_fall   = ~vs_s_q[1] & vs_s_q[2];
  assign href_fall = ~href_s_q[1] & href_s_q[2];
  assign href_lvl  = href_s_q[1];
  assign byte_s    = dat_s2_q;

  // Two-flop synchronizers plus one history flop for edge detection
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      pclk_s_q <= '0;
      vs_s_q   <= '0;
      href_s_q <= '0;
      dat_s1_q <= '0;
      dat_s2_q <= '0;
    end else begin
      pclk_s_q <= {pclk_s_q[1:0], cam.pclk_cam};
      vs_s_q   <= {vs_s_q[1:0], cam.vsync_cam};
      href_s_q <= {href_s_q[1:0], cam.href_cam};
      dat_s1_q <= cam.wdata_cam;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Pixel keep decision, bounds test and row-major address for the current pixel
  always_comb begin
`ifdef CAM_DECIMATE_EN
    keep_d      = ~pix_odd_q & ~line_odd_q;
    keep_line_d = ~line_odd_q;
`else
    keep_d      = 1'b1;
    keep_line_d = 1'b1;
`endif
    in_bounds_d = (col_q < CW'(H_PIX)) && (row_q < RW'(V_PIX));
    addr_d      = AW'(row_q) * AW'(H_PIX) + AW'(col_q);
  end

  // Frame FSM with line/pixel counters; a completed in-bounds pixel enters stage p0
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      phase_q      <= 1'b0;
      r_q          <= '0;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
      vld_p0       <= 1'b0;
      addr_p0      <= '0;
      pix_p0       <= '0;
`ifdef CAM_DECIMATE_EN
      pix_odd_q    <= 1'b0;
      line_odd_q   <= 1'b0;
`endif
    end else begin
      vld_p0       <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vs_rise) state_q <= WAIT_VS;
        end
        WAIT_VS: begin
          if (vs_fall) begin
            if (cam.cap_en) begin
              state_q    <= ACTIVE;
              col_q      <= '0;
              row_q      <= '0;
              phase_q    <= 1'b0;
`ifdef CAM_DECIMATE_EN
              pix_odd_q  <= 1'b0;
              line_odd_q <= 1'b0;
`endif
            end else begin
              state_q <= IDLE;
            end
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            // frame ends (possibly mid-line); counters restart at next frame start
            state_q      <= WAIT_VS;
            frame_done_q <= 1'b1;
            phase_q      <= 1'b0;
          end else begin
            if (pclk_rise && href_lvl) begin
              if (!phase_q) begin
                r_q     <= byte_s[3:0];
                phase_q <= 1'b1;
              end else begin
                phase_q <= 1'b0;
`ifdef CAM_DECIMATE_EN
                pix_odd_q <= ~pix_odd_q;
`endif
                if (keep_d) begin
                  if (in_bounds_d) begin
                    vld_p0  <= 1'b1;
                    addr_p0 <= addr_d;
                    pix_p0  <= {r_q, byte_s};
                    col_q   <= col_q + CW'(1);
                  end else begin
                    ovf_q <= 1'b1;
                  end
                end
              end
            end
            // line end is applied after the byte above so it wins on col/phase
            if (href_fall) begin
              col_q   <= '0;
              phase_q <= 1'b0;
`ifdef CAM_DECIMATE_EN
              pix_odd_q  <= 1'b0;
              line_odd_q <= ~line_odd_q;
`endif
              if (keep_line_d && (row_q != RW'(V_PIX))) row_q <= row_q + RW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output stage p1: registered write strobe, suppressed once the frame has ended
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= vld_p0 && (state_q == ACTIVE) && !vs_rise;
      if (vld_p0) begin
        waddr_q <= addr_p0;
        wdata_q <= pix_p0;
      end
    end
  end

  assign cam.waddr      = waddr_q;
  assign cam.wdata      = wdata_q;
  assign cam.wen        = wen_q;
  assign cam.frame_done = frame_done_q;
  assign cam.ovf        = ovf_q;

endmodule

// File: tb/tb_cam_capture.sv
// Testbench for cam_capture: randomized camera traffic, a frame-level
// reference model feeding an expected-write queue, and an independent monitor
// that checks every write strobe against that queue.
module tb_cam_capture;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cam_capture_if #(.AW(AW)) cif();

  cam_capture #(.H_PIX(H), .V_PIX(V), .AW(AW)) dut (
    .CLK100MHZ(clk),
    .rst_n    (rst_n),
    .cam      (cif.slave)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [11:0]   d;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  int  wr_seen = 0, wr_exp = 0, fd_seen = 0, fd_exp = 0;
  int  last_addr_seen = -1, last_addr_exp = -1;

  // reference model state (frame/line/pixel indices of the camera stream)
  bit       cap_prev = 0;
  bit       ovf_m = 0;
  bit       phase = 0;
  bit       line_has_bytes = 0;
  int       line_j = 0, pix_i = 0;
  logic [3:0] r_m;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n) begin
      if (cif.wen) begin
        checks++;
        wr_seen++;
        last_addr_seen = int'(cif.waddr);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wen actual=a:%0d d:%03h required=no write", cif.waddr, cif.wdata);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.a !== cif.waddr || mon_e.d !== cif.wdata) begin
            errors++;
            $display("FAIL write actual=a:%0d d:%03h required=a:%0d d:%03h",
                     cif.waddr, cif.wdata, mon_e.a, mon_e.d);
          end
        end
      end
      if (cif.frame_done) fd_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  // reference model for one camera byte
  task automatic model_byte(logic [7:0] b);
    int col, row;
    bit keep;
    if (!cap_prev) return;
    if (!phase) begin
      r_m   = b[3:0];
      phase = 1;
    end else begin
      phase = 0;
`ifdef CAM_DECIMATE_EN
      keep = (pix_i % 2 == 0) && (line_j % 2 == 0);
      col  = pix_i / 2;
      row  = line_j / 2;
`else
      keep = 1;
      col  = pix_i;
      row  = line_j;
`endif
      if (keep) begin
        if (col < H && row < V) begin
          exp_q.push_back('{a: AW'(row * H + col), d: {r_m, b}});
          wr_exp++;
          last_addr_exp = row * H + col;
        end else begin
          ovf_m = 1;
        end
      end
      pix_i++;
    end
  endtask

  task automatic send_byte(logic [7:0] b);
    cif.pclk_cam  = 1'b0;
    cif.wdata_cam = b;
    cif.href_cam  = 1'b1;
    line_has_bytes = 1;
    model_byte(b);
    cyc(2);
    cif.pclk_cam = 1'b1;
    cyc(2);
  endtask

  task automatic end_line();
    cif.pclk_cam = 1'b0;
    cif.href_cam = 1'b0;
    if (line_has_bytes) line_j++;
    line_has_bytes = 0;
    phase = 0;
    pix_i = 0;
    cyc(4);
  endtask

  task automatic send_line(int nbytes);
    for (int k = 0; k < nbytes; k++) send_byte(8'($urandom_range(0, 255)));
    end_line();
  endtask

  // frame boundary: vsync high then low; a line in flight is abandoned
  task automatic vsync_pulse(bit cap);
    cif.cap_en = cap;
    cyc(1);
    cif.vsync_cam = 1'b1;
    if (cap_prev) fd_exp++;
    cap_prev = cap;
    cyc(3);
    cif.pclk_cam = 1'b0;
    cif.href_cam = 1'b0;
    line_j = 0;
    pix_i = 0;
    phase = 0;
    line_has_bytes = 0;
    cyc(3);
    cif.vsync_cam = 1'b0;
    cyc(6);
  endtask

  task automatic checkpoint(string name);
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) cyc(1);
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_wr_cnt"}, wr_seen, wr_exp);
    check({name, "_fd_cnt"}, fd_seen, fd_exp);
    check({name, "_ovf"}, int'(cif.ovf), int'(ovf_m));
  endtask

  initial begin
    cif.pclk_cam  = 1'b0;
    cif.vsync_cam = 1'b0;
    cif.href_cam  = 1'b0;
    cif.wdata_cam = 8'h00;
    cif.cap_en    = 1'b1;
    rst_n = 1'b0;
    cyc(3);
    check("rst_waddr", int'(cif.waddr), 0);
    check("rst_wdata", int'(cif.wdata), 0);
    check("rst_wen", int'(cif.wen), 0);
    check("rst_frame_done", int'(cif.frame_done), 0);
    check("rst_ovf", int'(cif.ovf), 0);
    rst_n = 1'b1;
    cyc(3);

    // directed 4-byte line
    vsync_pulse(1);
    send_byte(8'h0A); send_byte(8'h5C); send_byte(8'h03); send_byte(8'hF1);
    end_line();
    checkpoint("directed");
`ifndef CAM_DECIMATE_EN
    check("directed_last_addr", last_addr_seen, 1);
`endif

    // full frame of incrementing pixels
    vsync_pulse(1);
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        send_byte(8'((r * H + c) >> 4));
        send_byte(8'(r * H + c));
      end
      end_line();
    end
    checkpoint("full_frame");
    check("full_last_addr", last_addr_seen, last_addr_exp);
`ifndef CAM_DECIMATE_EN
    check("full_last_addr_const", last_addr_seen, H * V - 1);
`endif

    // over-long line, then a normal one
    vsync_pulse(1);
    send_line(2 * H + 2);
    send_line(2 * H);
    checkpoint("long_line");
`ifndef CAM_DECIMATE_EN
    check("long_line_ovf_set", int'(cif.ovf), 1);
`endif

    // capture disabled for one frame, then enabled
    vsync_pulse(0);
    send_line(2 * H);
    send_line(2 * H);
    checkpoint("cap_off");
    vsync_pulse(1);
    send_line(2 * H);
    checkpoint("cap_on");

    // vsync arriving mid-line (row 2, col 3, dangling even byte)
    vsync_pulse(1);
    send_line(2 * H);
    send_line(2 * H);
    for (int k = 0; k < 7; k++) send_byte(8'($urandom_range(0, 255)));
    cyc(4);
    vsync_pulse(1);
    send_line(2 * H);
    checkpoint("abort");

    // randomized frames
    for (int f = 0; f < 10; f++) begin
      int nl;
      vsync_pulse(bit'($urandom_range(0, 3) != 0));
      nl = $urandom_range(0, V + 2);
      for (int l = 0; l < nl; l++) send_line($urandom_range(1, 2 * H + 3));
      checkpoint("rand");
    end

    // reset in the middle of a captured line
    vsync_pulse(1);
    send_line(2 * H);
    for (int k = 0; k < 5; k++) send_byte(8'($urandom_range(0, 255)));
    cyc(4);
    checkpoint("pre_reset");
    rst_n = 1'b0;
    cyc(2);
    check("mid_rst_wen", int'(cif.wen), 0);
    check("mid_rst_waddr", int'(cif.waddr), 0);
    check("mid_rst_ovf", int'(cif.ovf), 0);
    exp_q.delete();
    cap_prev = 0;
    ovf_m = 0;
    phase = 0;
    pix_i = 0;
    rst_n = 1'b1;
    cyc(2);
    for (int k = 0; k < 2 * H; k++) send_byte(8'($urandom_range(0, 255)));
    end_line();
    send_line(2 * H);
    checkpoint("post_reset_idle");
    vsync_pulse(1);
    send_line(2 * H);
    send_line(2 * H);
    vsync_pulse(0);
    checkpoint("post_reset_capture");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
